// File: rtl/cam_search_ctrl.sv
// CAM search controller: arbitrates writes against searches into an external CAM,
// then streams each search hit to a consumer with a ready/valid handshake.
`timescale 1ns/1ps
module cam_search_ctrl #(
  parameter int CAM_DW  = 32,
  parameter int CAM_MW  = 3,
  parameter int CAM_AW  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [CAM_DW-1:0] i_wr_data,
  input  logic [CAM_AW-1:0] i_wr_addr,
  input  logic              i_srch_valid,
  output logic              o_srch_ready,
  input  logic [CAM_MW-1:0] i_srch_mask,
  input  logic [CAM_MW-1:0] i_srch_strb,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [CAM_DW-1:0] o_res_data,
  output logic [CAM_AW-1:0] o_res_addr,
  output logic              o_srch_done,
  output logic [CAM_AW:0]   o_hit_cnt,
  output logic [CAM_DW-1:0] o_cam_data_in,
  output logic              o_cam_input_valid,
  output logic [CAM_AW-1:0] o_cam_addr_in,
  output logic [CAM_MW-1:0] o_cam_mask_in,
  output logic [CAM_MW-1:0] o_cam_mask_strb,
  output logic              o_cam_mask_en,
  output logic              o_cam_data_valid,
  input  logic [CAM_DW-1:0] i_cam_data_out,
  input  logic [CAM_AW-1:0] i_cam_addr_out,
  input  logic              i_cam_hit
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_HIT, PRESENT, ACK, DONE} state_t;

  state_t              r_state;
  logic                r_rr;
  logic [TW-1:0]       r_timer;
  logic [CAM_AW:0]     r_hit_cnt;
  logic                r_res_valid;
  logic [CAM_DW-1:0]   r_res_data;
  logic [CAM_AW-1:0]   r_res_addr;
  logic                r_srch_done;
  logic [CAM_DW-1:0]   r_cam_data_in;
  logic                r_cam_input_valid;
  logic [CAM_AW-1:0]   r_cam_addr_in;
  logic [CAM_MW-1:0]   r_cam_mask_in;
  logic [CAM_MW-1:0]   r_cam_mask_strb;
  logic                r_cam_mask_en;
  logic                r_cam_data_valid;

  logic w_idle;
  logic w_wr_go;
  logic w_srch_go;

  // r_rr low means the write side owns the next contested grant.
  assign w_idle       = (r_state == IDLE);
  assign o_wr_ready   = w_idle & (!i_srch_valid | !r_rr);
  assign o_srch_ready = w_idle & (!i_wr_valid | r_rr);
  assign w_wr_go      = i_wr_valid & o_wr_ready;
  assign w_srch_go    = i_srch_valid & o_srch_ready;

  assign o_res_valid       = r_res_valid;
  assign o_res_data        = r_res_data;
  assign o_res_addr        = r_res_addr;
  assign o_srch_done       = r_srch_done;
  assign o_hit_cnt         = r_hit_cnt;
  assign o_cam_data_in     = r_cam_data_in;
  assign o_cam_input_valid = r_cam_input_valid;
  assign o_cam_addr_in     = r_cam_addr_in;
  assign o_cam_mask_in     = r_cam_mask_in;
  assign o_cam_mask_strb   = r_cam_mask_strb;
  assign o_cam_mask_en     = r_cam_mask_en;
  assign o_cam_data_valid  = r_cam_data_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= IDLE;
      r_rr              <= 1'b0;
      r_timer           <= '0;
      r_hit_cnt         <= '0;
      r_res_valid       <= 1'b0;
      r_res_data        <= '0;
      r_res_addr        <= '0;
      r_srch_done       <= 1'b0;
      r_cam_data_in     <= '0;
      r_cam_input_valid <= 1'b0;
      r_cam_addr_in     <= '0;
      r_cam_mask_in     <= '0;
      r_cam_mask_strb   <= '0;
      r_cam_mask_en     <= 1'b0;
      r_cam_data_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_go) begin
            r_cam_addr_in     <= i_wr_addr;
            r_cam_data_in     <= i_wr_data;
            r_cam_input_valid <= 1'b1;
            r_rr              <= 1'b1;
            r_state           <= WRITE;
          end else if (w_srch_go) begin
            r_cam_mask_in   <= i_srch_mask;
            r_cam_mask_strb <= i_srch_strb;
            r_cam_mask_en   <= 1'b1;
            r_hit_cnt       <= '0;
            r_timer         <= '0;
            r_rr            <= 1'b0;
            r_state         <= WAIT_HIT;
          end
        end
        WRITE: begin
          r_cam_input_valid <= 1'b0;
          r_state           <= IDLE;
        end
        WAIT_HIT: begin
          if (i_cam_hit) begin
            r_res_data  <= i_cam_data_out;
            r_res_addr  <= i_cam_addr_out;
            r_res_valid <= 1'b1;
            r_state     <= PRESENT;
          end else if (r_timer == TW'(TIMEOUT)) begin
            r_cam_mask_en <= 1'b0;
            r_srch_done   <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        PRESENT: begin
          if (i_res_ready) begin
            r_res_valid      <= 1'b0;
            r_hit_cnt        <= r_hit_cnt + (CAM_AW + 1)'(1);
            r_cam_data_valid <= 1'b1;
            r_state          <= ACK;
          end
        end
        ACK: begin
          // The CAM is still popping this hit, so cam_hit is not trusted here.
          r_cam_data_valid <= 1'b0;
          if (r_hit_cnt[CAM_AW]) begin
            r_cam_mask_en <= 1'b0;
            r_srch_done   <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_timer <= '0;
            r_state <= WAIT_HIT;
          end
        end
        DONE: begin
          r_srch_done <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Directed bench for cam_search_ctrl with a small behavioural CAM (4 entries)
// answering lookups; CAM_AW=2 so the full-hit-count exit is reachable.
`timescale 1ns/1ps
module tb_cam_search_ctrl;

  localparam int DW = 32;
  localparam int MW = 3;
  localparam int AW = 2;
  localparam int TO = 15;
  localparam logic [DW-1:0] ENTRY = {3'b100, 29'h7};

  logic          clk;
  logic          rstN;
  logic          wrValid;
  logic          wrReady;
  logic [DW-1:0] wrData;
  logic [AW-1:0] wrAddr;
  logic          srchValid;
  logic          srchReady;
  logic [MW-1:0] srchMask;
  logic [MW-1:0] srchStrb;
  logic          resValid;
  logic          resReady;
  logic [DW-1:0] resData;
  logic [AW-1:0] resAddr;
  logic          srchDone;
  logic [AW:0]   hitCnt;
  logic [DW-1:0] camDataIn;
  logic          camInputValid;
  logic [AW-1:0] camAddrIn;
  logic [MW-1:0] camMaskIn;
  logic [MW-1:0] camMaskStrb;
  logic          camMaskEn;
  logic          camDataValid;
  logic [DW-1:0] camDataOut;
  logic [AW-1:0] camAddrOut;
  logic          camHit;

  int vectors     = 0;
  int miscompares = 0;
  int nCycles;
  logic sawResValid;

  cam_search_ctrl #(.CAM_DW(DW), .CAM_MW(MW), .CAM_AW(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_wr_valid(wrValid), .o_wr_ready(wrReady), .i_wr_data(wrData), .i_wr_addr(wrAddr),
    .i_srch_valid(srchValid), .o_srch_ready(srchReady),
    .i_srch_mask(srchMask), .i_srch_strb(srchStrb),
    .o_res_valid(resValid), .i_res_ready(resReady), .o_res_data(resData), .o_res_addr(resAddr),
    .o_srch_done(srchDone), .o_hit_cnt(hitCnt),
    .o_cam_data_in(camDataIn), .o_cam_input_valid(camInputValid), .o_cam_addr_in(camAddrIn),
    .o_cam_mask_in(camMaskIn), .o_cam_mask_strb(camMaskStrb), .o_cam_mask_en(camMaskEn),
    .o_cam_data_valid(camDataValid),
    .i_cam_data_out(camDataOut), .i_cam_addr_out(camAddrOut), .i_cam_hit(camHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External CAM: stores writes, reports the lowest matching entry at or above
  // the pop pointer, and advances past it on each hit acknowledge.
  logic [DW-1:0] camMem [4];
  logic          camVld [4] = '{default: 1'b0};
  logic [2:0]    camPtr = 3'd0;

  always @(posedge clk) begin
    if (camInputValid) begin
      camMem[camAddrIn] <= camDataIn;
      camVld[camAddrIn] <= 1'b1;
    end
    if (!camMaskEn) camPtr <= 3'd0;
    else if (camDataValid) camPtr <= {1'b0, camAddrOut} + 3'd1;
  end

  always_comb begin
    camHit     = 1'b0;
    camDataOut = '0;
    camAddrOut = '0;
    for (int k = 3; k >= 0; k--) begin
      if (camMaskEn && camVld[k] && (k >= int'(camPtr)) &&
          (((camMem[k][DW-1:DW-MW] ^ camMaskIn) & camMaskStrb) == '0)) begin
        camHit     = 1'b1;
        camDataOut = camMem[k];
        camAddrOut = k[AW-1:0];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic sv, input logic rr);
    wrValid   = wv;
    srchValid = sv;
    resReady  = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Runs until srch_done or a 40-cycle budget, noting any res_valid seen.
  task automatic waitDone(output int n);
    n = 0;
    while (!srchDone && n < 40) begin
      tick;
      n++;
      if (resValid) sawResValid = 1'b1;
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    wrData   = ENTRY;
    wrAddr   = '0;
    srchMask = '0;
    srchStrb = 3'b111;
    sawResValid = 1'b0;
    repeat (3) tick;
    checkOutput("rst_input_valid", 32'(camInputValid), 0);
    checkOutput("rst_mask_en", 32'(camMaskEn), 0);
    checkOutput("rst_res_valid", 32'(resValid), 0);
    checkOutput("rst_srch_done", 32'(srchDone), 0);
    checkOutput("rst_hit_cnt", 32'(hitCnt), 0);
    checkOutput("rst_wr_ready", 32'(wrReady), 1);
    checkOutput("rst_srch_ready", 32'(srchReady), 1);
    rstN = 1'b1;

    // Four back-to-back writes: one accepted every other cycle.
    wrValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wrAddr = AW'(i);
      checkOutput("wr_ready_idle", 32'(wrReady), 1);
      tick;
      checkOutput("wr_strobe", 32'(camInputValid), 1);
      checkOutput("wr_addr", 32'(camAddrIn), 32'(i));
      checkOutput("wr_data", camDataIn, ENTRY);
      checkOutput("wr_ready_busy", 32'(wrReady), 0);
      tick;
      checkOutput("wr_strobe_off", 32'(camInputValid), 0);
    end
    wrValid = 1'b0;

    // Four-hit search; the fourth hit saturates hit_cnt and ends the search from ACK.
    srchMask = 3'b100;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("srch_ready", 32'(srchReady), 1);
    tick;
    srchValid = 1'b0;
    checkOutput("mask_en_on", 32'(camMaskEn), 1);
    checkOutput("mask_in", 32'(camMaskIn), 32'h4);
    checkOutput("mask_strb", 32'(camMaskStrb), 32'h7);
    checkOutput("hit_cnt_clr", 32'(hitCnt), 0);
    for (int h = 0; h < 4; h++) begin
      tick;
      checkOutput("res_valid", 32'(resValid), 1);
      checkOutput("res_addr", 32'(resAddr), 32'(h));
      checkOutput("res_data", resData, ENTRY);
      tick;
      checkOutput("ack_pulse", 32'(camDataValid), 1);
      checkOutput("ack_hit_cnt", 32'(hitCnt), 32'(h + 1));
      checkOutput("ack_res_valid", 32'(resValid), 0);
      tick;
      checkOutput("ack_pulse_off", 32'(camDataValid), 0);
    end
    checkOutput("full_done", 32'(srchDone), 1);
    checkOutput("full_mask_en", 32'(camMaskEn), 0);
    checkOutput("full_hit_cnt", 32'(hitCnt), 4);
    tick;
    checkOutput("done_pulse_off", 32'(srchDone), 0);
    checkOutput("hit_cnt_held", 32'(hitCnt), 4);

    // Miss search: done lands TIMEOUT+1 cycles after cam_mask_en rises.
    srchMask = 3'b010;
    srchValid = 1'b1;
    tick;
    srchValid = 1'b0;
    checkOutput("miss_mask_en", 32'(camMaskEn), 1);
    sawResValid = 1'b0;
    waitDone(nCycles);
    checkOutput("miss_latency", 32'(nCycles), 32'(TO + 1));
    checkOutput("miss_hit_cnt", 32'(hitCnt), 0);
    checkOutput("miss_no_result", 32'(sawResValid), 0);
    checkOutput("miss_mask_off", 32'(camMaskEn), 0);
    tick;

    // Consumer stalls longer than TIMEOUT: result must hold and no ack escapes.
    srchMask = 3'b100;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick;
    srchValid = 1'b0;
    tick;
    for (int c = 0; c < 20; c++) begin
      checkOutput("stall_valid", 32'(resValid), 1);
      checkOutput("stall_addr", 32'(resAddr), 0);
      checkOutput("stall_data", resData, ENTRY);
      checkOutput("stall_no_ack", 32'(camDataValid), 0);
      checkOutput("stall_no_done", 32'(srchDone), 0);
      tick;
    end
    resReady = 1'b1;
    tick;
    checkOutput("stall_ack", 32'(camDataValid), 1);
    checkOutput("stall_hit_cnt", 32'(hitCnt), 1);
    tick;
    tick;
    checkOutput("second_valid", 32'(resValid), 1);
    checkOutput("second_addr", 32'(resAddr), 1);

    // Asynchronous reset while a result is presented.
    #1 rstN = 1'b0;
    #1;
    checkOutput("arst_res_valid", 32'(resValid), 0);
    checkOutput("arst_mask_en", 32'(camMaskEn), 0);
    checkOutput("arst_hit_cnt", 32'(hitCnt), 0);
    checkOutput("arst_srch_done", 32'(srchDone), 0);
    checkOutput("arst_ack", 32'(camDataValid), 0);
    tick;
    checkOutput("arst_no_done", 32'(srchDone), 0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick;
    srchValid = 1'b0;
    checkOutput("post_rst_hit_cnt", 32'(hitCnt), 0);
    tick;
    checkOutput("post_rst_addr", 32'(resAddr), 0);
    tick;
    checkOutput("post_rst_cnt1", 32'(hitCnt), 1);

    // Both requesters held high out of reset: write, search, write.
    rstN = 1'b0;
    wrAddr = 2'd3;
    srchMask = 3'b010;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick;
    rstN = 1'b1;
    checkOutput("arb_wr_first", 32'(wrReady), 1);
    checkOutput("arb_srch_wait", 32'(srchReady), 0);
    tick;
    checkOutput("arb_wr_strobe", 32'(camInputValid), 1);
    checkOutput("arb_srch_busy", 32'(srchReady), 0);
    tick;
    checkOutput("arb_srch_turn", 32'(srchReady), 1);
    checkOutput("arb_wr_blocked", 32'(wrReady), 0);
    tick;
    checkOutput("arb_srch_run", 32'(camMaskEn), 1);
    checkOutput("arb_wr_stall", 32'(wrReady), 0);
    sawResValid = 1'b0;
    waitDone(nCycles);
    checkOutput("arb_srch_latency", 32'(nCycles), 32'(TO + 1));
    checkOutput("arb_wr_stall_done", 32'(wrReady), 0);
    tick;
    checkOutput("arb_wr_again", 32'(wrReady), 1);
    checkOutput("arb_srch_yield", 32'(srchReady), 0);
    tick;
    checkOutput("arb_wr_strobe2", 32'(camInputValid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
